pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the PLL wrapper and runs in the PLL output clock domain.
- Consumes the raw, asynchronous PLL lock and the board reset, and produces staged, synchronous, active-high resets for the design.
- Qualifies lock with a stability counter and filters lock-loss glitches while running.
- Reports readiness and keeps a saturating count of lock-loss events.

Parameters:
- LOCK_CYCLES, 1024: consecutive synced-lock-high cycles required before staging starts (>=1).
- STAGE_GAP, 16: cycles between successive stage releases (>=1).
- NUM_STAGES, 3: number of reset outputs, released in index order (1..8).
- LOSS_CYCLES, 4: consecutive synced-lock-low cycles in RUN that declare a lock loss (>=1).
- HOLD_CYCLES, 64: cycles all resets stay asserted in LOST before re-qualifying (>=1).

Ports:
- clock, in, 1: PLL output clock; sole clock.
- reset_n, in, 1: asynchronous active-low reset.
- pll_lock, in, 1: raw PLL lock; asynchronous.
- soft_reset, in, 1: synchronous pulse that forces a full re-sequence.
- rst_out, out, NUM_STAGES: active-high synchronous resets; bit 0 is released first.
- ready, out, 1: high only in RUN.
- loss_count, out, 8: saturating count of lock-loss events.
- state_dbg, out, 3: encoded FSM state.

Behaviour:
- reset_n handling:
  - Assertion is asynchronous: all outputs and state go to reset values immediately.
  - Release is synchronised by a 2-flop chain, so internal reset ends after the 2nd rising edge with reset_n high.
- pll_lock synchroniser: 2 flops, reset to 0, giving lock_s 2 cycles after pll_lock.
- Reset values: rst_out all ones, ready 0, loss_count 0, state WAIT_LOCK, all counters 0.
- Encodings: WAIT_LOCK=0, STAGING=1, RUN=2, LOST=3.
- WAIT_LOCK:
  - lock_s=0 clears cnt.
  - lock_s=1 increments cnt.
  - lock_s=1 with cnt==LOCK_CYCLES-1 moves to STAGING with cnt=0, idx=0.
- STAGING:
  - gap counter increments each cycle.
  - When it reaches STAGE_GAP-1: rst_out[idx] is cleared, idx increments, gap resets.
  - Release of bit NUM_STAGES-1 moves to RUN; ready rises on that same edge.
  - Any lock_s=0 goes to LOST (no filtering before RUN).
- RUN:
  - loss counter increments while lock_s=0 and clears on lock_s=1.
  - Reaching LOSS_CYCLES goes to LOST.
  - Glitches shorter than LOSS_CYCLES have no effect.
- Entering LOST from a lock loss:
  - rst_out goes all ones and ready goes 0 on the transition edge.
  - loss_count increments, saturating at 255.
- LOST: rst_out is held for HOLD_CYCLES, then the FSM moves to WAIT_LOCK with cnt=0. pll_lock is ignored during the hold.
- soft_reset:
  - In WAIT_LOCK, STAGING or RUN it moves to LOST without incrementing loss_count.
  - It is ignored in LOST.
  - If soft_reset and a lock-loss trigger occur in the same cycle, it counts as a loss and loss_count increments.
- Release ordering is monotonic: rst_out[k] is never released before rst_out[k-1].
  - Any return to LOST reasserts all bits simultaneously.
- rst_out and ready are driven directly from flops, with no combinational path from the inputs.
- Cycle timing, with edge 1 being the first rising edge with reset_n high and pll_lock steady high:
  - rst_out[0] releases at edge 4+LOCK_CYCLES+STAGE_GAP.
  - rst_out[k] releases at edge 4+LOCK_CYCLES+(k+1)*STAGE_GAP.

Decomposition:
- Shared package holds:
  - the state encoding constants (WAIT_LOCK/STAGING/RUN/LOST);
  - the loss_count width (8);
  - a counter-width helper (clog2) used to size cnt, gap and hold counters.
- One natural sub-module: sync2, a 2-flop synchroniser with async reset and a parameterised reset value.
  - Instance 1: reset-release chain, with input 1.
  - Instance 2: pll_lock, with reset value 0.

Test Plan:
All cases use LOCK_CYCLES=16, STAGE_GAP=4, NUM_STAGES=3, LOSS_CYCLES=4, HOLD_CYCLES=8 unless stated.
- Clean start: pll_lock held high, reset_n released -> rst_out goes 111->110 at edge 24, 100 at edge 28, 000 at edge 32; ready=1 at edge 32; state_dbg=2.
- Lock chatter: pll_lock toggles every 10 cycles -> rst_out stays 111, state stays 0, loss_count stays 0.
- RUN glitch: a 3-cycle low pulse on pll_lock -> no change. A 4-cycle low pulse -> LOST, rst_out=111, ready=0, loss_count=1; after 8 hold cycles, re-qualify and the release sequence repeats.
- Lock drop during STAGING, one cycle after rst_out[0] releases -> all bits reassert; loss_count=1.
- soft_reset pulse in RUN -> LOST with loss_count unchanged. soft_reset coincident with the 4th low cycle -> loss_count increments. 300 forced losses -> loss_count saturates at 255.
- reset_n asserted mid-STAGING -> rst_out=111, ready=0 and loss_count=0 asynchronously, before the next edge; the sequence restarts from WAIT_LOCK after release.

Source files
------------

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM encoding, loss counter
// width and the helper that sizes the internal cycle counters.
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STAGING   = 3'd1,
    RUN       = 3'd2,
    LOST      = 3'd3
  } seq_state_e;

  localparam int LOSS_COUNT_W = 8;
  localparam logic [LOSS_COUNT_W-1:0] LOSS_COUNT_MAX = '1;

  // Bits needed to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset and a
// parameterised reset value.
module pll_reset_sequencer_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, releases staged active-high resets in index order,
// filters lock glitches while running and counts lock-loss events.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int LOCK_CYCLES = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int NUM_STAGES  = 3,
  parameter int LOSS_CYCLES = 4,
  parameter int HOLD_CYCLES = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    pll_lock,
  input  logic                    soft_reset,
  output logic [NUM_STAGES-1:0]   rst_out,
  output logic                    ready,
  output logic [LOSS_COUNT_W-1:0] loss_count,
  output logic [2:0]              state_dbg
);

  localparam int CNT_W  = cnt_width(LOCK_CYCLES);
  localparam int GAP_W  = cnt_width(STAGE_GAP);
  localparam int IDX_W  = cnt_width(NUM_STAGES);
  localparam int LOW_W  = cnt_width(LOSS_CYCLES);
  localparam int HOLD_W = cnt_width(HOLD_CYCLES);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);
  localparam logic [LOW_W-1:0]  LOW_LAST  = LOW_W'(LOSS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic rst_int_n;
  logic lock_s;

  // Reset release is synchronised; assertion stays asynchronous.
  pll_reset_sequencer_sync2 #(.RST_VAL(1'b0)) u_rst_sync (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .d_i    (1'b1),
    .q_o    (rst_int_n)
  );

  pll_reset_sequencer_sync2 #(.RST_VAL(1'b0)) u_lock_sync (
    .clk_i  (clock),
    .rst_ni (rst_int_n),
    .d_i    (pll_lock),
    .q_o    (lock_s)
  );

  seq_state_e              state_q,      state_d;
  logic [CNT_W-1:0]        cnt_q,        cnt_d;
  logic [GAP_W-1:0]        gap_q,        gap_d;
  logic [IDX_W-1:0]        idx_q,        idx_d;
  logic [LOW_W-1:0]        low_q,        low_d;
  logic [HOLD_W-1:0]       hold_q,       hold_d;
  logic [NUM_STAGES-1:0]   rst_out_q,    rst_out_d;
  logic                    ready_q,      ready_d;
  logic [LOSS_COUNT_W-1:0] loss_count_q, loss_count_d;

  logic go_lost;
  logic lock_loss;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    idx_d        = idx_q;
    low_d        = low_q;
    hold_d       = hold_q;
    rst_out_d    = rst_out_q;
    loss_count_d = loss_count_q;
    go_lost      = 1'b0;
    lock_loss    = 1'b0;

    unique case (state_q)
      WAIT_LOCK: begin
        if (soft_reset) begin
          go_lost = 1'b1;
        end else if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STAGING;
          cnt_d   = '0;
          gap_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STAGING: begin
        // No glitch filtering before RUN: a single low cycle aborts staging.
        if (!lock_s) begin
          go_lost   = 1'b1;
          lock_loss = 1'b1;
        end else if (soft_reset) begin
          go_lost = 1'b1;
        end else if (gap_q == GAP_LAST) begin
          gap_d = '0;
          idx_d = idx_q + 1'b1;
          for (int k = 0; k < NUM_STAGES; k++) begin
            if (idx_q == IDX_W'(k)) begin
              rst_out_d[k] = 1'b0;
            end
          end
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
            idx_d   = '0;
            low_d   = '0;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      RUN: begin
        // A lock loss wins over a coincident soft_reset so it is counted.
        if (!lock_s && (low_q == LOW_LAST)) begin
          go_lost   = 1'b1;
          lock_loss = 1'b1;
        end else if (soft_reset) begin
          go_lost = 1'b1;
        end else if (!lock_s) begin
          low_d = low_q + 1'b1;
        end else begin
          low_d = '0;
        end
      end

      LOST: begin
        if (hold_q == HOLD_LAST) begin
          state_d = WAIT_LOCK;
          hold_d  = '0;
          cnt_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: begin
        state_d   = WAIT_LOCK;
        rst_out_d = '1;
      end
    endcase

    if (go_lost) begin
      state_d   = LOST;
      hold_d    = '0;
      cnt_d     = '0;
      gap_d     = '0;
      idx_d     = '0;
      low_d     = '0;
      rst_out_d = '1;
    end

    if (lock_loss && (loss_count_q != LOSS_COUNT_MAX)) begin
      loss_count_d = loss_count_q + 1'b1;
    end

    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      gap_q        <= '0;
      idx_q        <= '0;
      low_q        <= '0;
      hold_q       <= '0;
      rst_out_q    <= '1;
      ready_q      <= 1'b0;
      loss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      idx_q        <= idx_d;
      low_q        <= low_d;
      hold_q       <= hold_d;
      rst_out_q    <= rst_out_d;
      ready_q      <= ready_d;
      loss_count_q <= loss_count_d;
    end
  end

  assign rst_out    = rst_out_q;
  assign ready      = ready_q;
  assign loss_count = loss_count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge
// monitor pops and compares them against the sequencer outputs.
module tb_pll_reset_sequencer;

  localparam int NS = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          pll_lock = 1'b0;
  logic          soft_reset = 1'b0;
  logic [NS-1:0] rst_out;
  logic          ready;
  logic [7:0]    loss_count;
  logic [2:0]    state_dbg;

  pll_reset_sequencer #(
    .LOCK_CYCLES (16),
    .STAGE_GAP   (4),
    .NUM_STAGES  (NS),
    .LOSS_CYCLES (4),
    .HOLD_CYCLES (8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pll_lock   (pll_lock),
    .soft_reset (soft_reset),
    .rst_out    (rst_out),
    .ready      (ready),
    .loss_count (loss_count),
    .state_dbg  (state_dbg)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [2:0] ro;
    logic       rd;
    logic [2:0] st;
    logic [7:0] lc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic expect_at(input int c, input logic [2:0] ro, input logic rd,
                           input logic [2:0] st, input logic [7:0] lc);
    exp_t e;
    e.c = c; e.ro = ro; e.rd = rd; e.st = st; e.lc = lc;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req, input int c);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, c, act, req);
    end
  endtask

  // Monitor: compares every expectation due at this cycle.
  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.c < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL stale_expectation: due cycle %0d, now %0d", mon_e.c, cyc);
      end else begin
        $display("cycle %0d: rst_out=%b ready=%b state=%0d loss_count=%0d", cyc,
                 rst_out, ready, state_dbg, loss_count);
        chk("rst_out", {5'd0, rst_out}, {5'd0, mon_e.ro}, cyc);
        chk("ready", {7'd0, ready}, {7'd0, mon_e.rd}, cyc);
        chk("state_dbg", {5'd0, state_dbg}, {5'd0, mon_e.st}, cyc);
        chk("loss_count", loss_count, mon_e.lc, cyc);
      end
    end
  end

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Asserts reset_n (checking the asynchronous effect before the next edge),
  // holds it for 3 edges and returns the cycle after which reset_n is high.
  task automatic do_reset(input logic lk, output int b);
    reset_n    = 1'b0;
    pll_lock   = lk;
    soft_reset = 1'b0;
    expect_at(cyc, 3'b111, 1'b0, 3'd0, 8'd0);
    wait_edge(cyc + 3);
    reset_n = 1'b1;
    b = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, s, r, m, m2;
    wait_edge(1);

    // Lock chatter: high phases of 10 cycles never qualify.
    do_reset(1'b0, a);
    expect_at(a + 12, 3'b111, 1'b0, 3'd0, 8'd0);
    expect_at(a + 27, 3'b111, 1'b0, 3'd0, 8'd0);
    expect_at(a + 42, 3'b111, 1'b0, 3'd0, 8'd0);
    expect_at(a + 57, 3'b111, 1'b0, 3'd0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      pll_lock = (i % 2 == 1);
      wait_edge(a + 10 * (i + 1));
    end

    // Clean start: releases at edges 24, 28, 32.
    do_reset(1'b1, b);
    expect_at(b + 19, 3'b111, 1'b0, 3'd0, 8'd0);
    expect_at(b + 20, 3'b111, 1'b0, 3'd1, 8'd0);
    expect_at(b + 23, 3'b111, 1'b0, 3'd1, 8'd0);
    expect_at(b + 24, 3'b110, 1'b0, 3'd1, 8'd0);
    expect_at(b + 27, 3'b110, 1'b0, 3'd1, 8'd0);
    expect_at(b + 28, 3'b100, 1'b0, 3'd1, 8'd0);
    expect_at(b + 31, 3'b100, 1'b0, 3'd1, 8'd0);
    expect_at(b + 32, 3'b000, 1'b1, 3'd2, 8'd0);
    wait_edge(b + 35);

    // RUN glitches: 3 low cycles ignored, 4 low cycles declare a loss.
    m  = cyc;
    m2 = m + 12;
    expect_at(m + 6,   3'b000, 1'b1, 3'd2, 8'd0);
    expect_at(m + 8,   3'b000, 1'b1, 3'd2, 8'd0);
    expect_at(m2 + 5,  3'b000, 1'b1, 3'd2, 8'd0);
    expect_at(m2 + 6,  3'b111, 1'b0, 3'd3, 8'd1);
    expect_at(m2 + 13, 3'b111, 1'b0, 3'd3, 8'd1);
    expect_at(m2 + 14, 3'b111, 1'b0, 3'd0, 8'd1);
    expect_at(m2 + 29, 3'b111, 1'b0, 3'd0, 8'd1);
    expect_at(m2 + 30, 3'b111, 1'b0, 3'd1, 8'd1);
    expect_at(m2 + 34, 3'b110, 1'b0, 3'd1, 8'd1);
    expect_at(m2 + 38, 3'b100, 1'b0, 3'd1, 8'd1);
    expect_at(m2 + 41, 3'b100, 1'b0, 3'd1, 8'd1);
    expect_at(m2 + 42, 3'b000, 1'b1, 3'd2, 8'd1);
    pll_lock = 1'b0;
    wait_edge(m + 3);
    pll_lock = 1'b1;
    wait_edge(m2);
    pll_lock = 1'b0;
    wait_edge(m2 + 4);
    pll_lock = 1'b1;
    wait_edge(m2 + 45);

    // Lock drop one cycle after rst_out[0] releases, then soft_reset cases.
    do_reset(1'b1, b);
    expect_at(b + 24,  3'b110, 1'b0, 3'd1, 8'd0);
    expect_at(b + 25,  3'b111, 1'b0, 3'd3, 8'd1);
    expect_at(b + 32,  3'b111, 1'b0, 3'd3, 8'd1);
    expect_at(b + 33,  3'b111, 1'b0, 3'd0, 8'd1);
    expect_at(b + 48,  3'b111, 1'b0, 3'd0, 8'd1);
    expect_at(b + 49,  3'b111, 1'b0, 3'd1, 8'd1);
    expect_at(b + 53,  3'b110, 1'b0, 3'd1, 8'd1);
    expect_at(b + 61,  3'b000, 1'b1, 3'd2, 8'd1);
    expect_at(b + 63,  3'b000, 1'b1, 3'd2, 8'd1);
    expect_at(b + 64,  3'b111, 1'b0, 3'd3, 8'd1);
    expect_at(b + 71,  3'b111, 1'b0, 3'd3, 8'd1);
    expect_at(b + 72,  3'b111, 1'b0, 3'd0, 8'd1);
    expect_at(b + 88,  3'b111, 1'b0, 3'd1, 8'd1);
    expect_at(b + 100, 3'b000, 1'b1, 3'd2, 8'd1);
    expect_at(b + 107, 3'b000, 1'b1, 3'd2, 8'd1);
    expect_at(b + 108, 3'b111, 1'b0, 3'd3, 8'd2);
    wait_edge(b + 22);
    pll_lock = 1'b0;
    wait_edge(b + 23);
    pll_lock = 1'b1;
    wait_edge(b + 63);
    soft_reset = 1'b1;
    wait_edge(b + 64);
    soft_reset = 1'b0;
    wait_edge(b + 102);
    pll_lock = 1'b0;
    wait_edge(b + 107);
    soft_reset = 1'b1;
    wait_edge(b + 108);
    soft_reset = 1'b0;
    wait_edge(b + 110);
    pll_lock = 1'b1;
    wait_edge(b + 112);

    // 300 forced losses during STAGING: loss_count saturates at 255.
    do_reset(1'b1, s);
    expect_at(s + 25,   3'b110, 1'b0, 3'd1, 8'd0);
    expect_at(s + 26,   3'b111, 1'b0, 3'd3, 8'd1);
    expect_at(s + 7616, 3'b111, 1'b0, 3'd3, 8'd254);
    expect_at(s + 7646, 3'b111, 1'b0, 3'd3, 8'd255);
    expect_at(s + 8996, 3'b111, 1'b0, 3'd3, 8'd255);
    expect_at(s + 9020, 3'b111, 1'b0, 3'd1, 8'd255);
    expect_at(s + 9025, 3'b110, 1'b0, 3'd1, 8'd255);
    for (int k = 0; k < 300; k++) begin
      wait_edge(s + 23 + 30 * k);
      pll_lock = 1'b0;
      wait_edge(s + 24 + 30 * k);
      pll_lock = 1'b1;
    end

    // reset_n mid-STAGING clears everything before the next edge, then restarts.
    wait_edge(s + 9026);
    do_reset(1'b1, r);
    expect_at(r + 19, 3'b111, 1'b0, 3'd0, 8'd0);
    expect_at(r + 20, 3'b111, 1'b0, 3'd1, 8'd0);
    expect_at(r + 24, 3'b110, 1'b0, 3'd1, 8'd0);
    wait_edge(r + 26);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
